des_dec_key_sched: RTL and testbench
====================================

Name: des_dec_key_sched

Overview:
- Iterative DES key schedule that generates the sixteen 48-bit round subkeys in decryption order, K16 first and K1 last.
- Sits between the key register and the round datapath, feeding one subkey per handshake.
- The DECRYPT parameter also supports forward order (K1..K16), so the encrypt and decrypt paths share one block.
- Bit numbering follows the DES standard convention: bit 1 is the MSB.

Parameters:
- DECRYPT, 1, 1 = emit K16..K1 using right rotations; 0 = emit K1..K16 using left rotations.

Ports:
- clk  input  1  single clock for the block; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  [1:64]  64-bit DES key; parity bits 8,16,...,64 are ignored.
- key_valid  input  1  key_in is valid this cycle.
- key_ready  output  1  block is idle and accepts a key.
- subkey_out  output  [1:48]  current round subkey, PC-2(C,D).
- subkey_valid  output  1  subkey_out is valid.
- subkey_ready  input  1  consumer accepts subkey_out this cycle.
- round_idx  output  4  round number of subkey_out (1..16 encoded as 1..16 mod 16, so 16 is 4'd0).
- last  output  1  subkey_out is the final subkey of the sequence (K1 when DECRYPT=1, K16 when DECRYPT=0).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; C and D registers clear to 0.
  - key_ready=1, subkey_valid=0, last=0, round_idx=0, subkey_out=0.
  - Reset overrides every other input. Reset mid-sequence aborts the sequence; no further subkeys are emitted.
- Shift schedule: s(r)=1 for r in {1,2,9,16}, else s(r)=2.
- State IDLE:
  - key_ready=1, subkey_valid=0.
  - On key_valid at an edge, PC-1 splits the key into C0 and D0 (28 bits each).
  - DECRYPT=1: load C16=C0 and D16=D0 (total rotation is 28), set round_idx=16.
  - DECRYPT=0: load rotl(C0,1) and rotl(D0,1), set round_idx=1.
  - Go to EMIT.
- State EMIT:
  - key_ready=0, subkey_valid=1, subkey_out=PC-2(C,D). subkey_out is a combinational function of the C/D registers only.
  - Latency: the first subkey is valid in the cycle after key acceptance.
  - Hold: while subkey_ready=0, C, D, round_idx, subkey_out and last stay stable.
  - On subkey_ready=1 with last=0, DECRYPT=1: C,D <= rotr by s(round_idx); round_idx decrements.
  - On subkey_ready=1 with last=0, DECRYPT=0: C,D <= rotl by s(round_idx+1); round_idx increments.
  - On subkey_ready=1 with last=1: go to IDLE, so key_ready=1 in the next cycle.
  - Minimum sequence: 16 handshake cycles + 1 load cycle. Back-to-back keys have 1 idle cycle between sequences.
- Input rules:
  - key_valid while in EMIT is ignored (key_ready=0); the key is not queued.
  - key_in is sampled only on the accepting edge.
  - subkey_ready while in IDLE has no effect.
- Wrap-around check: after all 16 rotations, C and D equal their load values. An assertion checks this at last in DECRYPT=0, where rotl(C16,0) must equal C0.

Test Plan:
- DECRYPT=1, key 0x133457799BBCDFF1, subkey_ready tied 1 -> first subkey_out=0xCB3D8B0E17F5 (round 16) the cycle after acceptance, then 0xBF918D3D3F0A (round 15). The 16th subkey is 0x1B02EFFC7072 with last=1. key_ready=1 on the following cycle.
- DECRYPT=0, same key -> K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, ..., K16=0xCB3D8B0E17F5 with last=1. The sequence matches the DECRYPT=1 sequence reversed.
- Key 0x0000000000000000 and key 0x0101010101010101 (parity-only bits) -> all 16 subkeys equal 0x000000000000.
- Random subkey_ready stalls (about 50% low) -> subkey_out and round_idx stay stable through each stall. The emitted sequence is identical to the no-stall run; key_valid pulses during EMIT are ignored.
- Assert rst at round 9 of a sequence -> next cycle subkey_valid=0 and key_ready=1. A new key accepted afterwards restarts cleanly from round 16.
- Back-to-back keys A then B with key_valid held high -> B is accepted exactly one cycle after A's last handshake. B's first subkey follows with no corruption from A.

Source files
------------

// File: rtl/des_dec_key_sched.sv
// Iterative DES key schedule: one PC-2 subkey per handshake, K16..K1 (DECRYPT=1) or K1..K16 (DECRYPT=0).
// First subkey is valid one cycle after key acceptance; C/D and round_idx hold while subkey_ready is low.
module des_dec_key_sched #(
  parameter bit DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [1:48] subkey_out,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Round 16 is encoded as 0, so the final round differs by direction.
  localparam logic [3:0] LAST_IDX = DECRYPT ? 4'd1 : 4'd0;

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [27:0] c0_q, d0_q;
  logic [3:0]  round_q, round_d;
  logic [55:0] cd0;

  // Internal vectors keep DES bit 1 at the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  function automatic logic two_shift(input logic [3:0] r);
    return !(r == 4'd1 || r == 4'd2 || r == 4'd9 || r == 4'd0);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign cd0        = pc1(key_in);
  assign subkey_out = pc2({c_q, d_q});
  assign round_idx  = round_q;

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    d_d          = d_q;
    round_d      = round_q;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    last         = (state_q == EMIT) && (round_q == LAST_IDX);
    unique case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          // Decrypt starts at C16/D16, which equal C0/D0 after 28 total rotations.
          if (DECRYPT) begin
            c_d     = cd0[55:28];
            d_d     = cd0[27:0];
            round_d = 4'd0;
          end else begin
            c_d     = rotl(cd0[55:28], 1'b0);
            d_d     = rotl(cd0[27:0], 1'b0);
            round_d = 4'd1;
          end
          state_d = EMIT;
        end
      end
      EMIT: begin
        subkey_valid = 1'b1;
        if (subkey_ready) begin
          if (last) begin
            state_d = IDLE;
          end else if (DECRYPT) begin
            c_d     = rotr(c_q, two_shift(round_q));
            d_d     = rotr(d_q, two_shift(round_q));
            round_d = round_q - 4'd1;
          end else begin
            c_d     = rotl(c_q, two_shift(round_q + 4'd1));
            d_d     = rotl(d_q, two_shift(round_q + 4'd1));
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      c0_q    <= '0;
      d0_q    <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      if (key_ready && key_valid) begin
        c0_q <= cd0[55:28];
        d0_q <= cd0[27:0];
      end
    end
  end

  // A full forward pass rotates each half by 28, landing back on the PC-1 output.
  always_ff @(posedge clk) begin
    if (!rst && !DECRYPT && last) begin
      wrap_check: assert (c_q == c0_q && d_q == d0_q);
    end
  end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: decrypt and encrypt instances checked against a reference key schedule.
module tb_des_dec_key_sched;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  ri;
    logic        lst;
  } exp_t;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, kv, sel_enc, subkey_ready;
  logic [1:64] key_in;
  logic        kv_d, kv_e, kr_d, kr_e, sv_d, sv_e, last_d, last_e;
  logic [3:0]  ri_d, ri_e;
  logic [1:48] sk_d, sk_e;
  logic        kr, sv, lst;
  logic [3:0]  ri;
  logic [47:0] sk;

  exp_t        sb[$];
  logic [47:0] dec_ref [16];
  int          checks = 0;
  int          errors = 0;

  assign kv_d = kv & ~sel_enc;
  assign kv_e = kv & sel_enc;

  always_comb begin
    kr  = sel_enc ? kr_e   : kr_d;
    sv  = sel_enc ? sv_e   : sv_d;
    lst = sel_enc ? last_e : last_d;
    ri  = sel_enc ? ri_e   : ri_d;
    sk  = sel_enc ? sk_e   : sk_d;
  end

  des_dec_key_sched #(.DECRYPT(1'b1)) dut_dec (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(kv_d), .key_ready(kr_d),
    .subkey_out(sk_d), .subkey_valid(sv_d), .subkey_ready(subkey_ready),
    .round_idx(ri_d), .last(last_d)
  );

  des_dec_key_sched #(.DECRYPT(1'b0)) dut_enc (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(kv_e), .key_ready(kr_e),
    .subkey_out(sk_e), .subkey_valid(sv_e), .subkey_ready(subkey_ready),
    .round_idx(ri_e), .last(last_e)
  );

  // Reference: K_r = PC2(rotl^n(C0), rotl^n(D0)), n = cumulative shift through round r.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int tot;
    tot = 0;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = key[6'(64 - PC1_T[i])];
      d[5'(27 - i)] = key[6'(64 - PC1_T[28 + i])];
    end
    for (int j = 0; j < r; j++) tot += SH[j];
    for (int t = 0; t < tot; t++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return k;
  endfunction

  function automatic void push_seq(input bit enc, input logic [63:0] key);
    exp_t e;
    int r;
    for (int n = 0; n < 16; n++) begin
      r     = enc ? n + 1 : 16 - n;
      e.sk  = model_key(key, r);
      e.ri  = 4'(r);
      e.lst = enc ? (r == 16) : (r == 1);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; kv = 1'b0; subkey_ready = 1'b0; key_in = '0; sel_enc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({kr_d, sv_d, last_d, ri_d, sk_d} !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0}) begin
      errors++;
      $display("FAIL reset_dec: got ready=%b valid=%b last=%b round=%0d subkey=%h, expected 1 0 0 0 0",
               kr_d, sv_d, last_d, ri_d, sk_d);
    end
    checks++;
    if ({kr_e, sv_e, last_e, ri_e, sk_e} !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0}) begin
      errors++;
      $display("FAIL reset_enc: got ready=%b valid=%b last=%b round=%0d subkey=%h, expected 1 0 0 0 0",
               kr_e, sv_e, last_e, ri_e, sk_e);
    end
    subkey_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (kr_d !== 1'b1 || sv_d !== 1'b0 || ri_d !== 4'd0) begin
      errors++;
      $display("FAIL idle_ready_ignored: got ready=%b valid=%b round=%0d, expected 1 0 0", kr_d, sv_d, ri_d);
    end
  endtask

  task automatic test_known_dec();
    exp_t e, o;
    int n, cyc;
    sb.delete(); sel_enc = 1'b0; subkey_ready = 1'b1;
    checks++;
    if (kr !== 1'b1) begin errors++; $display("FAIL dec_idle: key_ready=%b expected 1", kr); end
    key_in = KEY_A; kv = 1'b1; push_seq(1'b0, KEY_A);
    @(negedge clk);
    kv = 1'b0;
    checks++;
    if (sv !== 1'b1 || ri !== 4'd0 || sk !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL dec_first: got valid=%b round=%0d subkey=%h, expected 1 0 cb3d8b0e17f5", sv, ri, sk);
    end
    n = 0; cyc = 0;
    while (n < 16 && cyc < 100) begin
      if (sv && subkey_ready) begin
        e = sb.pop_front(); o = {sk, ri, lst};
        checks++;
        if (o !== e) begin errors++; $display("FAIL dec_seq[%0d]: got %h expected %h", n, o, e); end
        dec_ref[n] = sk; n++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL dec_timeout: got %0d subkeys expected 16", n); end
    checks++;
    if (dec_ref[1] !== 48'hBF918D3D3F0A || dec_ref[15] !== 48'h1B02EFFC7072) begin
      errors++;
      $display("FAIL dec_known: got K15=%h K1=%h expected bf918d3d3f0a 1b02effc7072", dec_ref[1], dec_ref[15]);
    end
    checks++;
    if (kr !== 1'b1 || sv !== 1'b0) begin
      errors++; $display("FAIL dec_return_idle: got ready=%b valid=%b expected 1 0", kr, sv);
    end
  endtask

  task automatic test_known_enc();
    exp_t e, o;
    int n, cyc;
    logic [47:0] got [16];
    sb.delete(); sel_enc = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    key_in = KEY_A; kv = 1'b1; push_seq(1'b1, KEY_A);
    @(negedge clk);
    kv = 1'b0;
    checks++;
    if (sv !== 1'b1 || ri !== 4'd1) begin
      errors++; $display("FAIL enc_first: got valid=%b round=%0d expected 1 1", sv, ri);
    end
    n = 0; cyc = 0;
    while (n < 16 && cyc < 100) begin
      if (sv && subkey_ready) begin
        e = sb.pop_front(); o = {sk, ri, lst};
        checks++;
        if (o !== e) begin errors++; $display("FAIL enc_seq[%0d]: got %h expected %h", n, o, e); end
        got[n] = sk; n++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL enc_timeout: got %0d subkeys expected 16", n); end
    checks++;
    if (got[0] !== 48'h1B02EFFC7072 || got[1] !== 48'h79AED9DBC9E5 || got[15] !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL enc_known: got K1=%h K2=%h K16=%h expected 1b02effc7072 79aed9dbc9e5 cb3d8b0e17f5",
               got[0], got[1], got[15]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== dec_ref[15 - i]) begin
        errors++; $display("FAIL enc_vs_dec_reversed[%0d]: got %h expected %h", i, got[i], dec_ref[15 - i]);
      end
    end
    checks++;
    if (kr !== 1'b1) begin errors++; $display("FAIL enc_return_idle: key_ready=%b expected 1", kr); end
  endtask

  task automatic test_zero_keys();
    exp_t e, o;
    int n, cyc;
    logic [63:0] key;
    for (int kk = 0; kk < 2; kk++) begin
      for (int en = 0; en < 2; en++) begin
        key = (kk == 1) ? 64'h0101010101010101 : 64'h0;
        sb.delete(); sel_enc = (en == 1); subkey_ready = 1'b1;
        @(negedge clk);
        key_in = key; kv = 1'b1; push_seq(en == 1, key);
        @(negedge clk);
        kv = 1'b0;
        n = 0; cyc = 0;
        while (n < 16 && cyc < 100) begin
          if (sv && subkey_ready) begin
            e = sb.pop_front(); o = {sk, ri, lst};
            checks++;
            if (o !== e || sk !== 48'h0) begin
              errors++; $display("FAIL zero_key[%0d][%0d][%0d]: got %h expected %h", kk, en, n, o, e);
            end
            n++;
          end
          @(negedge clk); cyc++;
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL zero_timeout[%0d][%0d]: got %0d expected 16", kk, en, n); end
      end
    end
  endtask

  task automatic test_stalls();
    exp_t e, o;
    int n, cyc;
    bit stalled;
    logic [47:0] p_sk;
    logic [3:0]  p_ri;
    logic        p_lst;
    sb.delete(); sel_enc = 1'b0; subkey_ready = 1'b0; stalled = 1'b0;
    p_sk = '0; p_ri = '0; p_lst = 1'b0;
    @(negedge clk);
    key_in = KEY_A; kv = 1'b1; push_seq(1'b0, KEY_A);
    @(negedge clk);
    key_in = KEY_B; kv = 1'b0;
    n = 0; cyc = 0;
    while (n < 16 && cyc < 400) begin
      subkey_ready = ($urandom_range(0, 1) == 1);
      kv = ($urandom_range(0, 3) == 0);
      if (stalled) begin
        checks++;
        if ({sk, ri, lst} !== {p_sk, p_ri, p_lst}) begin
          errors++;
          $display("FAIL stall_hold: got subkey=%h round=%0d last=%b expected %h %0d %b",
                   sk, ri, lst, p_sk, p_ri, p_lst);
        end
      end
      if (sv && subkey_ready) begin
        e = sb.pop_front(); o = {sk, ri, lst};
        checks++;
        if (o !== e || sk !== dec_ref[n]) begin
          errors++; $display("FAIL stall_seq[%0d]: got %h expected %h", n, o, e);
        end
        n++; stalled = 1'b0;
      end else begin
        stalled = sv; p_sk = sk; p_ri = ri; p_lst = lst;
      end
      @(negedge clk); cyc++;
    end
    kv = 1'b0;
    checks++;
    if (n != 16) begin errors++; $display("FAIL stall_timeout: got %0d subkeys expected 16", n); end
    checks++;
    if (kr !== 1'b1 || sv !== 1'b0) begin
      errors++; $display("FAIL stall_idle: got ready=%b valid=%b expected 1 0", kr, sv);
    end
    @(negedge clk);
    checks++;
    if (sv !== 1'b0) begin errors++; $display("FAIL stall_key_queued: valid=%b expected 0", sv); end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    int n, cyc;
    sb.delete(); sel_enc = 1'b0; subkey_ready = 1'b1;
    key_in = KEY_B; kv = 1'b1; push_seq(1'b0, KEY_B);
    @(negedge clk);
    kv = 1'b0;
    n = 0; cyc = 0;
    while (cyc < 100) begin
      if (sv && ri == 4'd9) break;
      if (sv && subkey_ready) begin
        e = sb.pop_front(); o = {sk, ri, lst};
        checks++;
        if (o !== e) begin errors++; $display("FAIL mid_seq[%0d]: got %h expected %h", n, o, e); end
        n++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL mid_reach_round9: got %0d handshakes expected 7", n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (sv !== 1'b0 || kr !== 1'b1 || ri !== 4'd0) begin
      errors++; $display("FAIL mid_reset: got valid=%b ready=%b round=%0d expected 0 1 0", sv, kr, ri);
    end
    sb.delete();
    key_in = KEY_A; kv = 1'b1;
    @(negedge clk);
    kv = 1'b0;
    checks++;
    if (sv !== 1'b1 || ri !== 4'd0 || sk !== 48'hCB3D8B0E17F5) begin
      errors++; $display("FAIL mid_restart: got valid=%b round=%0d subkey=%h expected 1 0 cb3d8b0e17f5", sv, ri, sk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int n, cyc, t_last, t_acc;
    sb.delete(); sel_enc = 1'b0; subkey_ready = 1'b1;
    @(negedge clk);
    key_in = KEY_A; kv = 1'b1; push_seq(1'b0, KEY_A);
    @(negedge clk);
    key_in = KEY_B; push_seq(1'b0, KEY_B);
    n = 0; cyc = 0; t_last = -1; t_acc = -1;
    while (n < 32 && cyc < 200) begin
      if (kr && kv && t_acc < 0 && n >= 16) t_acc = cyc;
      if (t_acc >= 0 && cyc > t_acc) kv = 1'b0;
      if (sv && subkey_ready) begin
        e = sb.pop_front(); o = {sk, ri, lst};
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_seq[%0d]: got %h expected %h", n, o, e); end
        n++;
        if (n == 16) t_last = cyc;
      end
      @(negedge clk); cyc++;
    end
    kv = 1'b0;
    checks++;
    if (n != 32) begin errors++; $display("FAIL b2b_timeout: got %0d subkeys expected 32", n); end
    checks++;
    if (t_last < 0 || t_acc != t_last + 1) begin
      errors++; $display("FAIL b2b_accept_gap: got accept cycle %0d expected %0d", t_acc, t_last + 1);
    end
  endtask

  initial begin
    test_reset();
    test_known_dec();
    test_known_enc();
    test_zero_keys();
    test_stalls();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
